icache_axi_refill: RTL

Cache-side-to-AXI4 read bridge that serves instruction-cache line refills. Accepts one outstanding line request from the icache refill port (address / request / ready / valid / data), issues a single AXI4 INCR read burst on the AR channel, gathers the R-channel beats into a full cache line, and returns it to the icache as a one-cycle valid pulse. Sits between the icache and the AXI interconnect; read-only, in-order, one transaction in flight.

---
 rtl/icache_axi_refill.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/icache_axi_refill.sv
// icache_axi_refill: bridges single icache line refill requests onto one AXI4 INCR read burst.
// Latency: request cycle + 1 AR cycle (+ arready wait) + beat cycles (+ rvalid gaps), then a 1-cycle rvalid_o pulse.
// Backpressure: rdy_o only in IDLE; arvalid_o held until arready_i; rvalid_i gaps stall the beat counter.
//
// Ports: icache side  rreq_i/addr_i/rdy_o in, rvalid_o/rlast_o/data_o/err_o out.
//        AXI AR       arid_o/araddr_o/arlen_o/arsize_o/arburst_o/arvalid_o out, arready_i in.
//        AXI R        rid_i/rdata_i/rresp_i/rlast_i/rvalid_i in, rready_o out.
// Optional macro AXI_REFILL_CHECK_EN: flags bad rresp, bad rid or misplaced rlast on err_o.
module icache_axi_refill #(
    parameter int                       ADDR_WIDTH      = 32,
    parameter int                       CACHELINE_WIDTH = 128,
    parameter int                       AXI_DATA_WIDTH  = 32,
    parameter int                       AXI_ID_WIDTH    = 4,
    parameter logic [AXI_ID_WIDTH-1:0]  AXI_ID          = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rreq_i,
    input  logic [ADDR_WIDTH-1:0]       addr_i,
    output logic                        rdy_o,
    output logic                        rvalid_o,
    output logic [1:0]                  rlast_o,
    output logic [CACHELINE_WIDTH-1:0]  data_o,
    output logic                        err_o,
    output logic [AXI_ID_WIDTH-1:0]     arid_o,
    output logic [ADDR_WIDTH-1:0]       araddr_o,
    output logic [7:0]                  arlen_o,
    output logic [2:0]                  arsize_o,
    output logic [1:0]                  arburst_o,
    output logic                        arvalid_o,
    input  logic                        arready_i,
    input  logic [AXI_ID_WIDTH-1:0]     rid_i,
    input  logic [AXI_DATA_WIDTH-1:0]   rdata_i,
    input  logic [1:0]                  rresp_i,
    input  logic                        rlast_i,
    input  logic                        rvalid_i,
    output logic                        rready_o
);

    localparam int BEATS      = CACHELINE_WIDTH / AXI_DATA_WIDTH;
    localparam int CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LINE_BYTES = CACHELINE_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ADDR_WIDTH'(LINE_BYTES - 1);

    typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_DONE} state_t;

    state_t                       state;
    state_t                       state_nxt;
    logic [ADDR_WIDTH-1:0]        araddr_q;
    logic [CNT_W-1:0]             cnt;
    logic [CACHELINE_WIDTH-1:0]   line_buf;
    logic [CACHELINE_WIDTH-1:0]   line_nxt;
    logic [CACHELINE_WIDTH-1:0]   data_q;
    logic                         accept;
    logic                         beat;

    assign accept = (state == S_IDLE) && rreq_i;
    assign beat   = (state == S_R) && rvalid_i;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (rreq_i)              state_nxt = S_AR;
            S_AR:    if (arready_i)           state_nxt = S_R;
            S_R:     if (rvalid_i && rlast_i) state_nxt = S_DONE;
            S_DONE:                           state_nxt = S_IDLE;
            default:                          state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from state; rdy_o is deliberately low in DONE so a held
    // rreq_i is only taken once the line has been handed back.
    always_comb begin
        rdy_o     = 1'b0;
        arvalid_o = 1'b0;
        rready_o  = 1'b0;
        rvalid_o  = 1'b0;
        rlast_o   = 2'b00;
        case (state)
            S_IDLE:  rdy_o     = rreq_i;
            S_AR:    arvalid_o = 1'b1;
            S_R:     rready_o  = 1'b1;
            S_DONE: begin
                rvalid_o = 1'b1;
                rlast_o  = 2'b01;
            end
            default: ;
        endcase
    end

    // Line assembly: the current beat lands in slot cnt; the counter wraps so
    // an overlong burst overwrites from slot 0 again.
    always_comb begin
        line_nxt = line_buf;
        if (beat) line_nxt[int'(cnt) * AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = rdata_i;
    end

    // Every well-formed burst rewrites all slots, so the assembly buffer needs no reset.
    always_ff @(posedge clk) begin
        line_buf <= line_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            araddr_q <= '0;
            cnt      <= '0;
            data_q   <= '0;
        end else begin
            if (accept) begin
                araddr_q <= addr_i & ~LINE_MASK;
                cnt      <= '0;
            end
            if (beat) cnt <= cnt + CNT_W'(1);
            // Publish the merged line (including the final beat) on entry to DONE.
            if (beat && rlast_i) data_q <= line_nxt;
        end
    end

`ifdef AXI_REFILL_CHECK_EN
    logic err_q;

    // Sticky per-transaction error: bad response, foreign ID, or rlast not
    // coinciding with the last slot (covers both early and late rlast).
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= 1'b0;
        end else if (beat && ((rresp_i != 2'b00) || (rid_i != AXI_ID) ||
                              (rlast_i != (cnt == CNT_W'(BEATS - 1))))) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = (state == S_DONE) && err_q;
`else
    logic unused_chk;
    assign unused_chk = ^{rid_i, rresp_i};
    assign err_o      = 1'b0;
`endif

    assign araddr_o  = araddr_q;
    assign data_o    = data_q;
    assign arid_o    = AXI_ID;
    assign arlen_o   = 8'(BEATS - 1);
    assign arsize_o  = 3'($clog2(AXI_DATA_WIDTH / 8));
    assign arburst_o = 2'b01;

endmodule
